// File: rtl/alu_seq_pkg.sv
// Shared types, widths and reference arithmetic for the ALU command sequencer.
// Latency: none (declarations and pure functions only).
// Backpressure: none; flow control lives in the modules that import this.
package alu_seq_pkg;

  localparam int OPND_W    = 4;
  localparam int RES_W     = 5;
  localparam int SEL_W     = 3;
  // Tag width carried through the command FIFO; the top-level TAG_W must match.
  localparam int SEQ_TAG_W = 4;

  typedef enum logic [SEL_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_MUL = 3'b100,
    OP_XOR = 3'b101,
    OP_MOD = 3'b110,
    OP_DIV = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPT,
    S_RESP
  } state_e;

  typedef struct packed {
    logic [OPND_W-1:0]    a;
    logic [OPND_W-1:0]    b;
    logic [SEL_W-1:0]     sel;
    logic [SEQ_TAG_W-1:0] tag;
  } cmd_t;

  // Divide or modulo by zero is refused locally and never reaches the ALU.
  function automatic logic is_zero_div(input logic [SEL_W-1:0] sel,
                                       input logic [OPND_W-1:0] b);
    return ((sel == OP_MOD) || (sel == OP_DIV)) && (b == '0);
  endfunction

  // Expected 5-bit ALU result; operands are zero-extended and results wrap mod 32.
  function automatic logic [RES_W-1:0] alu_ref(input logic [OPND_W-1:0] a,
                                               input logic [OPND_W-1:0] b,
                                               input logic [SEL_W-1:0]  sel);
    logic [RES_W-1:0] a_x;
    logic [RES_W-1:0] b_x;
    logic [RES_W-1:0] r;
    a_x = {1'b0, a};
    b_x = {1'b0, b};
    case (op_e'(sel))
      OP_ADD:  r = a_x + b_x;
      OP_SUB:  r = a_x - b_x;
      OP_AND:  r = a_x & b_x;
      OP_OR:   r = a_x | b_x;
      OP_MUL:  r = a_x * b_x;
      OP_XOR:  r = a_x ^ b_x;
      OP_MOD:  r = (b == '0) ? '0 : {1'b0, a % b};
      OP_DIV:  r = (b == '0) ? '0 : {1'b0, a / b};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_seq_fifo.sv
// Command FIFO for the sequencer: DEPTH entries of cmd_t, show-ahead read port.
// Latency: a pushed entry is visible on rd_data the cycle after the push edge.
// Backpressure: pushes while full and pops while empty are ignored; push and pop together keep count.
module alu_seq_fifo
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  cmd_t                       wr_data,
  input  logic                       pop,
  output cmd_t                       rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  cmd_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap naturally
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Feeds queued tagged commands to a registered 4-bit ALU one at a time and returns results in order.
// Latency: accept->rsp_valid after 3 edges (1 edge for a zero-divisor reject); at most one command per 4 cycles.
// Backpressure: cmd_ready drops when the FIFO is full; rsp_* hold until rsp_ready. Optional ALU_SEQ_REF_CHECK_EN adds result checking.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OPND_W-1:0] cmd_a,
  input  logic [OPND_W-1:0] cmd_b,
  input  logic [SEL_W-1:0]  cmd_sel,
  input  logic [TAG_W-1:0]  cmd_tag,
  output logic [OPND_W-1:0] alu_a,
  output logic [OPND_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [RES_W-1:0]  alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RES_W-1:0]  rsp_result,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_err,
  output logic              busy
`ifdef ALU_SEQ_REF_CHECK_EN
  ,
  output logic              rsp_mismatch,
  output logic              mismatch_sticky
`endif
);

  state_e                 state;
  state_e                 state_nxt;
  cmd_t                   fifo_in;
  cmd_t                   fifo_out;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   push;
  logic                   pop;
  logic                   load_issue;
  logic                   load_rej;
  logic                   load_capt;
  logic [TAG_W-1:0]       cur_tag;

  // Holding reset low also closes the command port, not just clearing state.
  assign cmd_ready = reset & ~fifo_full;
  assign push      = cmd_valid & cmd_ready;
  assign fifo_in   = '{a: cmd_a, b: cmd_b, sel: cmd_sel, tag: SEQ_TAG_W'(cmd_tag)};
  assign rsp_valid = (state == S_RESP);
  assign busy      = (state != S_IDLE) || (fifo_count != '0);

  alu_seq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data (fifo_in),
    .pop     (pop),
    .rd_data (fifo_out),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state and per-state load strobes
  always_comb begin
    state_nxt  = state;
    pop        = 1'b0;
    load_issue = 1'b0;
    load_rej   = 1'b0;
    load_capt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (is_zero_div(fifo_out.sel, fifo_out.b)) begin
            load_rej  = 1'b1;
            state_nxt = S_RESP;
          end else begin
            load_issue = 1'b1;
            state_nxt  = S_ISSUE;
          end
        end
      end
      S_ISSUE: state_nxt = S_CAPT;
      S_CAPT: begin
        load_capt = 1'b1;
        state_nxt = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ALU operand registers plus the in-flight tag; loaded only on issue so the ALU ports hold between commands
  always_ff @(posedge clk) begin
    if (!reset) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= '0;
      cur_tag <= '0;
    end else if (load_issue) begin
      alu_a   <= fifo_out.a;
      alu_b   <= fifo_out.b;
      alu_sel <= fifo_out.sel;
      cur_tag <= TAG_W'(fifo_out.tag);
    end
  end

  // Response registers: rejects load straight from the FIFO head, completions from the ALU result
  always_ff @(posedge clk) begin
    if (!reset) begin
      rsp_result <= '0;
      rsp_tag    <= '0;
      rsp_err    <= 1'b0;
    end else if (load_rej) begin
      rsp_result <= '0;
      rsp_tag    <= TAG_W'(fifo_out.tag);
      rsp_err    <= 1'b1;
    end else if (load_capt) begin
      rsp_result <= alu_result;
      rsp_tag    <= cur_tag;
      rsp_err    <= 1'b0;
    end
  end

`ifdef ALU_SEQ_REF_CHECK_EN
  logic ref_miss;

  // Operands are still held in CAPT, so the expected result comes from the issued registers
  assign ref_miss = (alu_ref(alu_a, alu_b, alu_sel) != alu_result);

  // Per-response mismatch flag and a sticky copy that only reset clears; rejects never flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      rsp_mismatch    <= 1'b0;
      mismatch_sticky <= 1'b0;
    end else if (load_rej) begin
      rsp_mismatch    <= 1'b0;
    end else if (load_capt) begin
      rsp_mismatch    <= ref_miss;
      mismatch_sticky <= mismatch_sticky | ref_miss;
    end
  end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: table vectors, hand-built reset/backpressure sequences, random stream vs a queue model.
// The ALU is modelled here as a one-cycle registered stand-in with an optional +1 fault for the reference-check build.
// Prints one TB_RESULT summary line.
module tb_alu_cmd_sequencer;
  import alu_seq_pkg::*;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic             clk;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_a;
  logic [3:0]       cmd_b;
  logic [2:0]       cmd_sel;
  logic [TAG_W-1:0] cmd_tag;
  logic [3:0]       alu_a;
  logic [3:0]       alu_b;
  logic [2:0]       alu_sel;
  logic [4:0]       alu_result = '0;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [4:0]       rsp_result;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;
  logic             busy;
`ifdef ALU_SEQ_REF_CHECK_EN
  logic             rsp_mismatch;
  logic             mismatch_sticky;
`endif
  logic             alu_fault = 1'b0;

  int checks   = 0;
  int failures = 0;

  alu_cmd_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_sel    (cmd_sel),
    .cmd_tag    (cmd_tag),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_tag    (rsp_tag),
    .rsp_err    (rsp_err),
    .busy       (busy)
`ifdef ALU_SEQ_REF_CHECK_EN
    ,
    .rsp_mismatch    (rsp_mismatch),
    .mismatch_sticky (mismatch_sticky)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Plain-integer ALU behaviour; results are the low 5 bits
  function automatic logic [4:0] spec_alu(input int a, input int b, input int sel);
    int r;
    case (sel)
      0: r = a + b;
      1: r = a - b;
      2: r = a & b;
      3: r = a | b;
      4: r = a * b;
      5: r = a ^ b;
      6: r = (b == 0) ? 0 : a % b;
      default: r = (b == 0) ? 0 : a / b;
    endcase
    return 5'(r);
  endfunction

  function automatic bit spec_reject(input int b, input int sel);
    return (sel >= 6) && (b == 0);
  endfunction

  // Registered ALU stand-in
  always @(posedge clk) alu_result <= spec_alu(alu_a, alu_b, alu_sel) + {4'd0, alu_fault};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One command into an idle block; reports latency and the response fields
  task automatic run_one(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel,
                         input logic [TAG_W-1:0] tag, output int lat, output logic [4:0] res,
                         output logic [TAG_W-1:0] rtag, output logic err, output logic mis,
                         output logic dropped);
    int w;
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_sel = sel; cmd_tag = tag;
    rsp_ready = 1'b1;
    w = 0;
    #1;
    while (!cmd_ready && w < 20) begin
      tick();
      w++;
    end
    if (w >= 20) begin
      checks++; failures++;
      $display("FAIL accept_timeout: cmd_ready stayed %0d, required 1", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    res  = rsp_result;
    rtag = rsp_tag;
    err  = rsp_err;
`ifdef ALU_SEQ_REF_CHECK_EN
    mis  = rsp_mismatch;
`else
    mis  = 1'b0;
`endif
    tick();
    dropped = !rsp_valid;
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic [3:0]       a;
    logic [3:0]       b;
    logic [2:0]       sel;
    logic [TAG_W-1:0] tag;
  } cmd_rec_t;

  typedef struct {
    logic [4:0]       res;
    logic [TAG_W-1:0] tag;
    logic             err;
  } rsp_rec_t;

  cmd_rec_t stim_q[$];
  rsp_rec_t exp_q[$];

  // Streams stim_q through the block; rsp_ready held low for the first 'hold' cycles
  task automatic run_stream(input int hold, input bit rnd, input int budget,
                            output int acc_at_hold, output logic rdy_at_hold);
    int cyc;
    int sent;
    rsp_rec_t e;
    cmd_rec_t c;
    cyc = 0; sent = 0; acc_at_hold = -1; rdy_at_hold = 1'bx;
    while ((stim_q.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
      cmd_valid = (stim_q.size() > 0) && (!rnd || $urandom_range(0, 3) != 0);
      if (stim_q.size() > 0) begin
        cmd_a = stim_q[0].a; cmd_b = stim_q[0].b; cmd_sel = stim_q[0].sel; cmd_tag = stim_q[0].tag;
      end
      rsp_ready = (cyc >= hold) && (!rnd || $urandom_range(0, 3) != 0);
      #1;
      if (cyc == hold) begin
        acc_at_hold = sent;
        rdy_at_hold = cmd_ready;
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL stream_extra: got tag %0d, required no response", rsp_tag);
        end else begin
          e = exp_q.pop_front();
          chk("stream_tag", rsp_tag, e.tag);
          chk("stream_result", rsp_result, e.res);
          chk("stream_err", rsp_err, e.err);
`ifdef ALU_SEQ_REF_CHECK_EN
          chk("stream_mismatch", rsp_mismatch, 0);
`endif
        end
      end
      if (cmd_valid && cmd_ready) begin
        c = stim_q.pop_front();
        e.tag = c.tag;
        e.err = spec_reject(c.b, c.sel);
        e.res = e.err ? 5'd0 : spec_alu(c.a, c.b, c.sel);
        exp_q.push_back(e);
        sent++;
      end
      tick();
      cyc++;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    chk("stream_leftover", stim_q.size() + exp_q.size(), 0);
    stim_q.delete();
    exp_q.delete();
  endtask

  typedef struct {
    logic [3:0]       a;
    logic [3:0]       b;
    logic [2:0]       sel;
    logic [TAG_W-1:0] tag;
    logic [4:0]       res;
    logic             err;
    int               lat;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int               lat;
    logic [4:0]       res;
    logic [TAG_W-1:0] rtag;
    logic             err;
    logic             mis;
    logic             dropped;
    logic [3:0]       last_a;
    logic [3:0]       last_b;
    logic [2:0]       last_sel;
    int               acc_h;
    logic             rdy_h;
    int               hits;
    cmd_rec_t         c;

    vecs[0]  = '{4'd9,  4'd8, 3'b000, 4'd1,  5'd17, 1'b0, 3};
    vecs[1]  = '{4'd7,  4'd0, 3'b111, 4'd2,  5'd0,  1'b1, 1};
    vecs[2]  = '{4'd7,  4'd3, 3'b110, 4'd3,  5'd1,  1'b0, 3};
    vecs[3]  = '{4'd15, 4'd15,3'b100, 4'd4,  5'd1,  1'b0, 3};
    vecs[4]  = '{4'd3,  4'd5, 3'b001, 4'd5,  5'd30, 1'b0, 3};
    vecs[5]  = '{4'hA,  4'h5, 3'b101, 4'd6,  5'd15, 1'b0, 3};
    vecs[6]  = '{4'hC,  4'hA, 3'b010, 4'd7,  5'd8,  1'b0, 3};
    vecs[7]  = '{4'hC,  4'h3, 3'b011, 4'd8,  5'd15, 1'b0, 3};
    vecs[8]  = '{4'd5,  4'd0, 3'b110, 4'd9,  5'd0,  1'b1, 1};
    vecs[9]  = '{4'd15, 4'd2, 3'b111, 4'd10, 5'd7,  1'b0, 3};
    vecs[10] = '{4'd15, 4'd15,3'b000, 4'd11, 5'd30, 1'b0, 3};
    vecs[11] = '{4'd0,  4'd1, 3'b001, 4'd12, 5'd31, 1'b0, 3};

    reset = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_sel = '0; cmd_tag = '0;
    tick();
    tick();
    chk("reset_cmd_ready", cmd_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_alu", {alu_a, alu_b, alu_sel}, 0);
    chk("reset_rsp", {rsp_result, rsp_tag, rsp_err}, 0);
    reset = 1'b1;
    tick();
    chk("post_reset_cmd_ready", cmd_ready, 1);
    last_a = '0; last_b = '0; last_sel = '0;

    for (int i = 0; i < 12; i++) begin
      run_one(vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].tag, lat, res, rtag, err, mis, dropped);
      if (!vecs[i].err) begin
        last_a = vecs[i].a; last_b = vecs[i].b; last_sel = vecs[i].sel;
      end
      chk($sformatf("vec%0d_result", i), res, vecs[i].res);
      chk($sformatf("vec%0d_tag", i), rtag, vecs[i].tag);
      chk($sformatf("vec%0d_err", i), err, vecs[i].err);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_rsp_drop", i), dropped, 1);
      chk($sformatf("vec%0d_alu_hold", i), {alu_a, alu_b, alu_sel}, {last_a, last_b, last_sel});
`ifdef ALU_SEQ_REF_CHECK_EN
      chk($sformatf("vec%0d_mismatch", i), mis, 0);
`endif
    end

    // Backpressure: 5 accepts (DEPTH queued + 1 in flight) then cmd_ready low, then drain in order
    for (int t = 0; t < 8; t++) begin
      c.a = 4'(t); c.b = 4'd1; c.sel = 3'b000; c.tag = TAG_W'(t);
      stim_q.push_back(c);
    end
    run_stream(12, 1'b0, 300, acc_h, rdy_h);
    chk("bp_accepts_before_stall", acc_h, DEPTH + 1);
    chk("bp_cmd_ready_stalled", rdy_h, 0);

    // Reset while tag 3 is in CAPT with tag 4 queued behind it
    cmd_valid = 1'b1; cmd_a = 4'd2; cmd_b = 4'd2; cmd_sel = 3'b000; cmd_tag = 4'd3;
    rsp_ready = 1'b1;
    tick();
    cmd_tag = 4'd4;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("capt_busy", busy, 1);
    reset = 1'b0;
    #1;
    chk("reset_low_cmd_ready", cmd_ready, 0);
    tick();
    chk("midreset_rsp_valid", rsp_valid, 0);
    chk("midreset_alu", {alu_a, alu_b, alu_sel}, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_cmd_ready", cmd_ready, 0);
    reset = 1'b1;
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rsp_valid) hits++;
    end
    chk("dropped_inflight_no_rsp", hits, 0);
    rsp_ready = 1'b0;
    run_one(4'd1, 4'd1, 3'b000, 4'd5, lat, res, rtag, err, mis, dropped);
    chk("after_reset_result", res, 2);
    chk("after_reset_tag", rtag, 5);
    chk("after_reset_latency", lat, 3);

    // Random stream with random gaps and random response backpressure
    for (int t = 0; t < 80; t++) begin
      c.a   = 4'($urandom_range(0, 15));
      c.sel = 3'($urandom_range(0, 7));
      c.b   = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      c.tag = TAG_W'(t);
      stim_q.push_back(c);
    end
    run_stream(0, 1'b1, 4000, acc_h, rdy_h);

`ifdef ALU_SEQ_REF_CHECK_EN
    alu_fault = 1'b1;
    run_one(4'd2, 4'd3, 3'b000, 4'd1, lat, res, rtag, err, mis, dropped);
    alu_fault = 1'b0;
    chk("fault_result", res, 6);
    chk("fault_mismatch", mis, 1);
    chk("fault_sticky", mismatch_sticky, 1);
    run_one(4'd4, 4'd4, 3'b000, 4'd2, lat, res, rtag, err, mis, dropped);
    chk("clean_mismatch", mis, 0);
    chk("clean_sticky_held", mismatch_sticky, 1);
    run_one(4'd1, 4'd0, 3'b111, 4'd3, lat, res, rtag, err, mis, dropped);
    chk("reject_mismatch", mis, 0);
    chk("reject_err", err, 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("sticky_after_reset", mismatch_sticky, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Initiator side of the registered 4-bit ALU interface. Accepts tagged operation commands over a valid/ready stream and buffers them in a small FIFO. Drives A/B/sel into the ALU one command at a time, samples the 5-bit result after the ALU's one-cycle register latency, and returns it in order on a valid/ready response stream. Sits between the testbench or host command source and the alu instance.

Parameters:
DEPTH, 4, command FIFO entries (power of 2, >=2)
TAG_W, 4, width of command/response tag

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at edge
cmd_a  in  4  operand A
cmd_b  in  4  operand B
cmd_sel  in  3  operation code
cmd_tag  in  TAG_W  command identifier, echoed in response
alu_a  out  4  to ALU A
alu_b  out  4  to ALU B
alu_sel  out  3  to ALU sel
alu_result  in  5  from ALU result
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid & rsp_ready at edge
rsp_result  out  5  captured ALU result
rsp_tag  out  TAG_W  tag of completed command
rsp_err  out  1  command rejected (divide/modulo by zero)
busy  out  1  FSM not IDLE or FIFO non-empty

Behaviour:
- Reset (reset==0 at edge): FIFO emptied; FSM->IDLE; alu_a/alu_b/alu_sel=0; rsp_valid=0, rsp_result=0, rsp_tag=0, rsp_err=0; busy=0. cmd_ready=0 while reset low. In-flight command is dropped silently.
- cmd_ready = !fifo_full (registered count, no push-through-when-full).
- FSM states: IDLE, ISSUE, CAPT, RESP.
- IDLE: if FIFO non-empty, pop at edge. If sel in {3'b110,3'b111} and B==0: load rsp_result=0, rsp_err=1, rsp_tag, go RESP; ALU ports unchanged. Otherwise register alu_a/alu_b/alu_sel from the entry, go ISSUE.
- ISSUE: operands held; the ALU registers its result at this edge; go CAPT.
- CAPT: load rsp_result<=alu_result, rsp_tag, rsp_err=0; go RESP.
- RESP: rsp_valid=1; hold all rsp_* until rsp_ready; on handshake go IDLE (rsp_valid low next cycle).
- alu_* outputs hold last issued values outside ISSUE/CAPT.
- Latency: command accepted at edge E0 into an empty idle block gives rsp_valid high after E3. A zero-divisor reject gives rsp_valid after E1. Throughput: one command per 4 cycles at most.
- Push and pop in the same cycle are both honoured; count unchanged.
- Responses leave strictly in acceptance order.
- Capacity: DEPTH queued + 1 in flight.

Optional Feature:
ALU_SEQ_REF_CHECK_EN. When defined:
- A reference model computes the expected 5-bit result from the issued operands:
  - add: zero-extend A and B, then add
  - sub: (A-B) mod 32
  - and/or/xor: zero-extended
  - mul: A*B mod 32
  - mod, div: B != 0 guaranteed
- In CAPT, compare against alu_result. Extra outputs: rsp_mismatch (1, valid with rsp_valid) and mismatch_sticky (1, set on any mismatch, cleared only by reset).
- Rejected commands never flag.

When not defined, these ports and the logic are absent.

Decomposition:
- Package alu_seq_pkg:
  - op_e enum: OP_ADD=000, OP_SUB=001, OP_AND=010, OP_OR=011, OP_MUL=100, OP_XOR=101, OP_MOD=110, OP_DIV=111
  - operand/result width constants (4, 5)
  - state_e enum
  - cmd_t packed struct {a, b, sel, tag}
- Sub-module alu_seq_fifo: synchronous FIFO of cmd_t, DEPTH entries, full/empty/count.

Test Plan:
1. ADD A=9 B=8 tag=1, rsp_ready=1 -> rsp_result=5'd17, rsp_tag=1, rsp_err=0, rsp_valid high 3 edges after accept.
2. DIV A=7 B=0 tag=2 -> rsp_err=1, rsp_result=0 one edge after pop; alu_sel unchanged; a following MOD A=7 B=3 -> result=1.
3. MUL A=15 B=15 -> 5'd1; SUB A=3 B=5 -> 5'd30; XOR A=4'hA B=4'h5 -> 5'd15.
4. rsp_ready=0, stream tags 0..7 -> cmd_ready low after 5 accepts; release rsp_ready -> responses tags 0..4 in order, then remaining accepted and completed.
5. reset low during CAPT of tag 3 -> next cycle rsp_valid=0, alu_*=0, busy=0, cmd_ready=0; tag 3 never responded; after release ADD 1+1 -> 5'd2.
6. ALU_SEQ_REF_CHECK_EN defined, ALU stub returns result+1 -> rsp_mismatch=1 on that response, mismatch_sticky stays 1 until reset.
